// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard controller: load-use bubbles, taken-branch flushes, multiply stalls
// and a saturating stall-cycle counter. Multiply sequencing needs HAZARD_MULT_STALL_EN.
module hazard_stall_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [REG_ADDR_W-1:0] RsD,
    input  logic [REG_ADDR_W-1:0] RtD,
    input  logic [REG_ADDR_W-1:0] RtE,
    input  logic                  MemtoRegE,
    input  logic                  RegWriteE,
    input  logic                  PCSrcD,
    input  logic                  MultStartE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  Busy,
    output logic [CNT_W-1:0]      StallCount
);

    logic             lu;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign lu = MemtoRegE & RegWriteE & (RtE != '0) & ((RtE == RsD) | (RtE == RtD));

`ifdef HAZARD_MULT_STALL_EN
    typedef enum logic {RUN, MULT_WAIT} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        FlushE  = 1'b0;
        Busy    = 1'b0;
        case (state_q)
            RUN: begin
                // A multiply freezes EX, so no bubble is needed even if lu is also true.
                if (MultStartE) begin
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    StallE  = 1'b1;
                    state_d = MULT_WAIT;
                    cnt_d   = 4'(MULT_CYCLES - 2);
                end else if (lu) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            MULT_WAIT: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                Busy   = 1'b1;
                if (cnt_q == 4'd0) state_d = RUN;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = RUN;
        endcase
    end
`else
    logic unused_mult;
    assign unused_mult = MultStartE;

    always_comb begin
        StallF = lu;
        StallD = lu;
        FlushE = lu;
        StallE = 1'b0;
        Busy   = 1'b0;
    end
`endif

    // A branch seen while ID is held will reappear after release, so it is simply dropped.
    assign FlushD = PCSrcD & ~StallD;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed cases then random traffic against a
// cycle-level model; a negedge monitor pops expected outputs and compares.
module tb_hazard_stall_unit;
    localparam int RW   = 5;
    localparam int MC   = 4;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_MULT_STALL_EN
    localparam bit MULTEN = 1'b1;
`else
    localparam bit MULTEN = 1'b0;
`endif

    typedef struct packed {
        logic          sf, sd, se, fd, fe, busy;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          CLK = 0;
    logic          RST = 0;
    logic [RW-1:0] RsD = 0, RtD = 0, RtE = 0;
    logic          MemtoRegE = 0, RegWriteE = 0, PCSrcD = 0, MultStartE = 0;
    logic          StallF, StallD, StallE, FlushD, FlushE, Busy;
    logic [CW-1:0] StallCount;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   m_wait = 0;   // cycles of multiply wait still to come
    int   m_cnt  = 0;   // model stall counter

    hazard_stall_unit #(.REG_ADDR_W(RW), .MULT_CYCLES(MC), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .RsD(RsD), .RtD(RtD), .RtE(RtE),
        .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE), .PCSrcD(PCSrcD),
        .MultStartE(MultStartE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .Busy(Busy), .StallCount(StallCount)
    );

    always #5 CLK = ~CLK;

    // Apply one cycle of inputs, predict this cycle's outputs, advance the model.
    task automatic step(input logic rst, input int rs, input int rt, input int rte,
                        input logic m2r, input logic rw, input logic pcs, input logic ms);
        exp_t e;
        logic lu;
        int   nxt;
        @(posedge CLK);
        #1;
        RST = rst; RsD = RW'(rs); RtD = RW'(rt); RtE = RW'(rte);
        MemtoRegE = m2r; RegWriteE = rw; PCSrcD = pcs; MultStartE = ms;
        if (!rst) begin
            m_wait = 0;
            m_cnt  = 0;
        end
        e   = '0;
        lu  = m2r && rw && (rte != 0) && (rte == rs || rte == rt);
        nxt = m_wait;
        if (m_wait > 0) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.busy = 1;
            nxt = m_wait - 1;
        end else if (MULTEN && ms) begin
            e.sf = 1; e.sd = 1; e.se = 1;
            nxt = MC - 1;
        end else if (lu) begin
            e.sf = 1; e.sd = 1; e.fe = 1;
        end
        e.fd  = pcs && !e.sd;
        e.cnt = CW'(m_cnt);
        exp_q.push_back(e);
        if (rst) begin
            m_wait = nxt;
            if (e.sf && m_cnt < CMAX) m_cnt++;
        end
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e, a;
            e = exp_q.pop_front();
            a = {StallF, StallD, StallE, FlushD, FlushE, Busy, StallCount};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got sf%b sd%b se%b fd%b fe%b busy%b cnt%0d want sf%b sd%b se%b fd%b fe%b busy%b cnt%0d",
                         $time, a.sf, a.sd, a.se, a.fd, a.fe, a.busy, a.cnt,
                         e.sf, e.sd, e.se, e.fd, e.fe, e.busy, e.cnt);
            end
        end
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // load-use on rs, then the same with rt index 0
        step(1, 5, 1, 5, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0, 0);
        // load-use on rt, and a non-writing load
        step(1, 2, 7, 7, 1, 1, 0, 0);
        step(1, 7, 7, 7, 1, 0, 0, 0);
        // multiply held high through its wait, then dropped
        for (int i = 0; i < MC; i++) step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // multiply together with load-use
        step(1, 3, 0, 3, 1, 1, 0, 1);
        for (int i = 1; i < MC; i++) step(1, 3, 0, 3, 1, 1, 1, 1);
        // back-to-back: held high on the RUN cycle after exit is a new multiply
        for (int i = 0; i < MC; i++) step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // branch alone, branch during load-use, branch re-asserted after
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 4, 0, 4, 1, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        // reset in the middle of a multiply wait
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // random traffic with small register indices to provoke collisions
        for (int i = 0; i < 400; i++) begin
            logic ms;
            ms = (m_wait > 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 5) == 0);
            step(($urandom_range(0, 99) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom), ms);
        end
        // drive the counter into saturation with continuous load-use stalls
        for (int i = 0; i < CMAX + 3; i++) step(1, 6, 0, 6, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        @(posedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller that produces the stall and flush controls consumed by the program counter, the IF/ID and ID/EX pipeline registers. It detects load-use hazards and taken branches. It also sequences multi-cycle multiply stalls with an internal FSM and counter, and keeps a saturating stall-cycle performance counter. It sits in the decode stage, beside the register file and branch comparator.

## Interface
- REG_ADDR_W, 5, register-index width.
- MULT_CYCLES, 4, total E-stage cycles of a multiply; legal range 2..16.
- CNT_W, 32, width of the stall performance counter.

- CLK  in  1  pipeline clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- RsD  in  REG_ADDR_W  rs index of the instruction in ID.
- RtD  in  REG_ADDR_W  rt index of the instruction in ID.
- RtE  in  REG_ADDR_W  rt index of the instruction in EX.
- MemtoRegE  in  1  EX instruction is a load.
- RegWriteE  in  1  EX instruction writes the register file.
- PCSrcD  in  1  branch or jump in ID resolved taken this cycle.
- MultStartE  in  1  EX instruction is a multiply (level, held while EX is stalled).
- StallF  out  1  1 freezes the PC (drives the PC's active-low load enable directly).
- StallD  out  1  1 holds the IF/ID register.
- StallE  out  1  1 holds the ID/EX register and the EX operands.
- FlushD  out  1  clears IF/ID at the next edge.
- FlushE  out  1  clears ID/EX at the next edge (bubble insert).
- Busy  out  1  FSM is in MULT_WAIT.
- StallCount  out  CNT_W  number of cycles in which StallF was 1.

## Operation
- FSM states: RUN and MULT_WAIT. There is a down-counter `cnt` of 4 bits.
- Load-use condition: lu = MemtoRegE & RegWriteE & (RtE != 0) & (RtE == RsD | RtE == RtD).
- Multiply condition: ms = MultStartE & (state == RUN).
- RUN with ms:
  - StallF = StallD = StallE = 1; FlushE = 0.
  - Next state is MULT_WAIT, with cnt = MULT_CYCLES-2.
  - ms has priority over lu.
- RUN with lu and not ms:
  - StallF = StallD = 1, FlushE = 1, StallE = 0.
  - State stays RUN.
- MULT_WAIT:
  - StallF = StallD = StallE = 1 and Busy = 1.
  - lu and MultStartE are ignored.
  - If cnt == 0, next state is RUN. Otherwise cnt decrements.
- FlushD = PCSrcD & ~StallD. A taken branch arriving during a stall stays in ID and re-asserts PCSrcD after the release, so no pending state is kept.
- FlushE and StallE are never both 1.
- StallCount increments on each edge where StallF = 1 and saturates at all-ones.

## Timing
- All stall and flush outputs are combinational from the inputs and the registered state. They are valid in the same cycle and take effect at the next rising CLK.
- A multiply asserted in cycle t gives StallE = 1 for cycles t .. t+MULT_CYCLES-1 (exactly MULT_CYCLES cycles). EX advances at the edge ending cycle t+MULT_CYCLES-1.
- A load-use hazard costs exactly 1 stall cycle per occurrence.
- Reset values:
  - state = RUN, cnt = 0, StallCount = 0.
  - With inputs at 0, all outputs are 0.
- Assertion of RST mid-MULT_WAIT returns to RUN immediately and clears cnt and StallCount.
- Back-to-back multiplies:
  - After returning to RUN, a held-high MultStartE is treated as a new multiply only if EX now holds a new instruction.
  - Because EX always advances on the exit edge, a high MultStartE in the RUN cycle after exit is a new multiply.

## Configuration
- HAZARD_MULT_STALL_EN defined: the multiply sequencing is compiled in, as described above.
- Undefined:
  - MULT_WAIT, cnt and the MultStartE logic are removed.
  - StallE and Busy are tied to 0.
  - MultStartE is left unused.
  - Only the load-use and branch behaviour remains.

## Test plan
- Reset: drive RST=0 mid-MULT_WAIT, then release -> Busy=0, StallCount=0, all stalls 0 with idle inputs.
- Load-use: MemtoRegE=1, RegWriteE=1, RtE=5, RsD=5 for one cycle -> StallF=StallD=FlushE=1 for 1 cycle and StallCount=1. Repeat with RtE=0 -> no stall.
- Multiply (macro on, MULT_CYCLES=4): MultStartE high from cycle 0 -> StallE=1 in cycles 0-3, Busy=1 in cycles 1-3, RUN at cycle 4, StallCount=4.
- Priority: MultStartE and lu together in RUN -> StallE=1, FlushE=0, FSM enters MULT_WAIT.
- Branch: PCSrcD=1 with no hazard -> FlushD=1. PCSrcD=1 during lu -> FlushD=0 that cycle, then FlushD=1 the cycle after.
- Saturation: preload or force StallCount to all-ones minus 1, hold a stall 3 cycles -> StallCount holds at all-ones.
